motor_pwm_driver: RTL and testbench

- Downstream consumer of the balance controller's signed per-wheel target speed; one instance per wheel (left, right).
- Converts the 10-bit signed target into a PWM duty plus direction for an H-bridge.
- Enforces slew limiting so commanded speed never steps abruptly.
- Enforces a dead interval on direction reversal so the bridge is never switched across zero under drive.

---
 rtl/motor_pwm_driver_pkg.sv | 48 ++++
 rtl/motor_pwm_driver_timebase.sv | 41 ++++
 rtl/motor_pwm_driver.sv | 169 ++++++++++++++++
 tb/tb_motor_pwm_driver.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/motor_pwm_driver_pkg.sv
// motor_pkg: shared types, constants and helpers for the motor PWM driver.
//   speed_t        10-bit signed wheel speed (-511..511 once clamped)
//   drv_state_t    driver FSM state: IDLE, RUN, DWELL
//   speed_mag()    magnitude of a speed as the 9-bit PWM duty
//   slew_toward()  move a speed toward a target by at most one slew step
package motor_pkg;

  typedef logic signed [9:0] speed_t;

  localparam speed_t     SPEED_MAX      = 10'sd511;
  // -512 is representable on the input but cannot be driven; it is clamped.
  localparam speed_t     SPEED_NEG_FULL = 10'sh200;
  localparam logic [8:0] PWM_TOP        = 9'd510;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DWELL = 2'd2
  } drv_state_t;

  // Magnitude of a clamped speed; -511..511 maps onto 0..511.
  function automatic logic [8:0] speed_mag(input speed_t s);
    speed_t a;
    a = s[9] ? -s : s;
    return a[8:0];
  endfunction

  // One slew step from cur toward tgt. The 11-bit intermediate keeps the
  // difference of two extreme speeds (up to +-1022) from wrapping.
  function automatic speed_t slew_toward(input speed_t cur, input speed_t tgt,
                                         input logic signed [10:0] step);
    logic signed [10:0] c;
    logic signed [10:0] t;
    logic signed [10:0] diff;
    logic signed [10:0] res;
    c    = {cur[9], cur};
    t    = {tgt[9], tgt};
    diff = t - c;
    if (diff > step)
      res = c + step;
    else if (diff < -step)
      res = c - step;
    else
      res = t;
    return res[9:0];
  endfunction

endpackage

// File: rtl/motor_pwm_driver_timebase.sv
// pwm_timebase: prescaler plus 511-count PWM period counter.
// Ports:
//   clock       system clock
//   reset       synchronous active-low reset; counters return to 0
//   pwm_cnt     current PWM count, 0..510
//   cnt_tick    high on the last prescaler count (pwm_cnt advances after it)
//   period_end  cnt_tick on count 510: last clock of the PWM period
// The timebase free-runs regardless of the driver's enable.
module pwm_timebase import motor_pkg::*; #(
  parameter int PRESCALE = 4
) (
  input  logic       clock,
  input  logic       reset,
  output logic [8:0] pwm_cnt,
  output logic       cnt_tick,
  output logic       period_end
);

  // A one-count prescaler still needs a 1-bit register to keep widths legal.
  localparam int            PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_reg;
  logic [8:0]    pwm_cnt_reg;

  assign cnt_tick   = (pre_reg == PRE_LAST);
  assign period_end = cnt_tick && (pwm_cnt_reg == PWM_TOP);
  assign pwm_cnt    = pwm_cnt_reg;

  always_ff @(posedge clock) begin
    if (!reset) begin
      pre_reg     <= '0;
      pwm_cnt_reg <= '0;
    end else begin
      pre_reg <= cnt_tick ? '0 : pre_reg + 1'b1;
      if (cnt_tick)
        pwm_cnt_reg <= (pwm_cnt_reg == PWM_TOP) ? 9'd0 : pwm_cnt_reg + 9'd1;
    end
  end

endmodule

// File: rtl/motor_pwm_driver.sv
// motor_pwm_driver: turns a signed per-wheel target speed into PWM duty and
// direction for an H-bridge, with slew limiting and a dead interval before
// any direction reversal.
// Ports:
//   clock          system clock
//   reset          synchronous active-low reset
//   enable         drive enable; 0 forces the output off within one clock
//   target_speed   signed target, -512..511 (-512 treated as -511)
//   pwm            registered bridge enable
//   dir            registered direction, 0 = forward, 1 = reverse
//   brake          registered brake request
//   applied_speed  signed speed currently being driven
//   period_tick    one-clock pulse on the first clock of each PWM period
// Build option: define MOTOR_PWM_BRAKE_EN to request braking in IDLE and
// DWELL; without it brake stays 0 and the motor coasts in those states.
module motor_pwm_driver import motor_pkg::*; #(
  parameter int PRESCALE     = 4,
  parameter int SLEW_STEP    = 8,
  parameter int DEAD_PERIODS = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic signed [9:0] target_speed,
  output logic              pwm,
  output logic              dir,
  output logic              brake,
  output logic signed [9:0] applied_speed,
  output logic              period_tick
);

  localparam int                 DW         = $clog2(DEAD_PERIODS + 1);
  localparam logic [DW-1:0]      DWELL_LOAD = DW'(DEAD_PERIODS);
  localparam logic signed [10:0] STEP       = 11'(SLEW_STEP);

  logic [8:0] pwm_cnt;
  logic       cnt_tick;
  logic       period_end;
  logic [8:0] cnt_next;

  pwm_timebase #(
    .PRESCALE (PRESCALE)
  ) u_timebase (
    .clock      (clock),
    .reset      (reset),
    .pwm_cnt    (pwm_cnt),
    .cnt_tick   (cnt_tick),
    .period_end (period_end)
  );

  // Count the timebase will hold after this edge; pwm is registered against
  // it so the output lines up with the count it belongs to.
  assign cnt_next = !cnt_tick ? pwm_cnt :
                    (pwm_cnt == PWM_TOP) ? 9'd0 : pwm_cnt + 9'd1;

  drv_state_t    state_reg, state_next;
  speed_t        applied_reg, applied_next;
  logic          dir_reg, dir_next;
  logic [DW-1:0] dwell_reg, dwell_next;
  logic          pwm_reg, pwm_next;
  logic          brake_reg, brake_next;
  logic          tick_reg;

  speed_t tgt;
  logic   tgt_neg;
  logic   tgt_pos;
  logic   opposite;

  always_comb begin
    tgt      = (target_speed == SPEED_NEG_FULL) ? -SPEED_MAX : target_speed;
    tgt_neg  = tgt[9];
    tgt_pos  = !tgt[9] && (tgt != '0);
    // A zero target never counts as a reversal request.
    opposite = dir_reg ? tgt_pos : tgt_neg;
  end

  always_comb begin
    state_next   = state_reg;
    applied_next = applied_reg;
    dir_next     = dir_reg;
    dwell_next   = dwell_reg;

    if (!enable) begin
      // Immediate shutdown; dir is kept so a later restart sees history.
      state_next   = IDLE;
      applied_next = '0;
      dwell_next   = '0;
    end else if (period_end) begin
      case (state_reg)
        IDLE: begin
          // First entry adopts the target sign without a dwell. Slewing
          // begins at the following period end, starting from 0.
          state_next   = RUN;
          applied_next = '0;
          if (tgt_neg)
            dir_next = 1'b1;
          else if (tgt_pos)
            dir_next = 1'b0;
        end
        RUN: begin
          if (opposite) begin
            // Ramp down to exactly zero, then wait out the dead interval.
            if (applied_reg == '0) begin
              state_next = DWELL;
              dwell_next = DWELL_LOAD;
            end else begin
              applied_next = slew_toward(applied_reg, '0, STEP);
            end
          end else begin
            applied_next = slew_toward(applied_reg, tgt, STEP);
          end
        end
        DWELL: begin
          dwell_next   = dwell_reg - 1'b1;
          applied_next = '0;
          if (dwell_reg == DW'(1)) begin
            state_next = RUN;
            // Flip only if the reversal is still being asked for.
            if (opposite)
              dir_next = ~dir_reg;
          end
        end
        default: begin
          state_next   = IDLE;
          applied_next = '0;
          dwell_next   = '0;
        end
      endcase
    end
  end

  always_comb begin
`ifdef MOTOR_PWM_BRAKE_EN
    brake_next = (state_next != RUN);
`else
    brake_next = 1'b0;
`endif
    // Duty is compared against the count it will be shown with, so a
    // magnitude of N gives exactly N high counts starting at count 0.
    pwm_next = !brake_next && (cnt_next < speed_mag(applied_next));
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg   <= IDLE;
      applied_reg <= '0;
      dir_reg     <= 1'b0;
      dwell_reg   <= '0;
      pwm_reg     <= 1'b0;
      brake_reg   <= 1'b0;
      tick_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      applied_reg <= applied_next;
      dir_reg     <= dir_next;
      dwell_reg   <= dwell_next;
      pwm_reg     <= pwm_next;
      brake_reg   <= brake_next;
      tick_reg    <= period_end;
    end
  end

  assign pwm           = pwm_reg;
  assign dir           = dir_reg;
  assign brake         = brake_reg;
  assign applied_speed = applied_reg;
  assign period_tick   = tick_reg;

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Scoreboard bench for motor_pwm_driver with PRESCALE=1, SLEW_STEP=8,
// DEAD_PERIODS=2. The stimulus process sets the target for each PWM period
// and queues the hand-computed state expected at the next period_tick; the
// monitor pops on every period_tick and also checks the pwm high-count and
// length of each completed period.
module tb_motor_pwm_driver;

`ifdef MOTOR_PWM_BRAKE_EN
  localparam bit BRAKE_ON = 1'b1;
`else
  localparam bit BRAKE_ON = 1'b0;
`endif

  logic              clock;
  logic              reset;
  logic              enable;
  logic signed [9:0] target_speed;
  logic              pwm;
  logic              dir;
  logic              brake;
  logic signed [9:0] applied_speed;
  logic              period_tick;

  motor_pwm_driver #(
    .PRESCALE     (1),
    .SLEW_STEP    (8),
    .DEAD_PERIODS (2)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .target_speed  (target_speed),
    .pwm           (pwm),
    .dir           (dir),
    .brake         (brake),
    .applied_speed (applied_speed),
    .period_tick   (period_tick)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int app;
    int dir;
    int brk;
    int high;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int app, input int d, input int hold, input int high);
    exp_t e;
    e.app  = app;
    e.dir  = d;
    e.brk  = BRAKE_ON ? hold : 0;
    e.high = high;
    sb.push_back(e);
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!period_tick && n < 1200);
    if (!period_tick) begin
      checks++;
      errors++;
      $display("FAIL tick_timeout: no period_tick after %0d clocks", n);
    end
  endtask

  // Next period: drive tgt, expect the given state at the following tick
  // and the given pwm high count over the period that tick opens.
  task automatic step_h(input int tgt, input int app, input int d,
                        input int hold, input int high);
    wait_tick();
    target_speed = 10'(tgt);
    push(app, d, hold, high);
  endtask

  task automatic step(input int tgt, input int app, input int d, input int hold);
    step_h(tgt, app, d, hold, (app < 0) ? -app : app);
  endtask

  // Monitor: one line per period_tick transaction.
  initial begin : monitor
    int   high_cnt;
    int   clk_cnt;
    int   prev_high;
    int   tick_no;
    bit   prev_valid;
    exp_t e;
    high_cnt   = 0;
    clk_cnt    = 0;
    prev_high  = 0;
    tick_no    = 0;
    prev_valid = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        prev_valid = 1'b0;
      end else if (period_tick) begin
        if (prev_valid) begin
          check("period_len", clk_cnt, 511);
          if (prev_high >= 0)
            check("pwm_high_count", high_cnt, prev_high);
        end
        prev_valid = 1'b0;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          tick_no++;
          $display("tick %0d: applied=%0d dir=%0d brake=%0d (expect %0d/%0d/%0d, duty %0d)",
                   tick_no, applied_speed, dir, brake, e.app, e.dir, e.brk, e.high);
          check("applied_speed", int'(applied_speed), e.app);
          check("dir", int'(dir), e.dir);
          check("brake", int'(brake), e.brk);
          prev_high  = e.high;
          prev_valid = 1'b1;
        end
        high_cnt = int'(pwm);
        clk_cnt  = 1;
      end else begin
        high_cnt += int'(pwm);
        clk_cnt++;
      end
    end
  end

  initial begin : watchdog
    #950000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    reset        = 1'b0;
    enable       = 1'b1;
    target_speed = 10'sd200;

    // Reset held for three clocks: everything stays cleared.
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      $display("reset clock %0d: pwm=%0d dir=%0d applied=%0d tick=%0d",
               i, pwm, dir, applied_speed, period_tick);
      check("reset_pwm", int'(pwm), 0);
      check("reset_dir", int'(dir), 0);
      check("reset_applied", int'(applied_speed), 0);
      check("reset_tick", int'(period_tick), 0);
      check("reset_brake", int'(brake), 0);
    end
    reset = 1'b1;

    // First period end: IDLE -> RUN, dir from +200, applied still 0.
    push(0, 0, 0, 0);

    // Slew up to +40.
    step(40, 8, 0, 0);
    step(40, 16, 0, 0);
    step(40, 24, 0, 0);
    step(40, 32, 0, 0);
    step(40, 40, 0, 0);

    // Back down to +16.
    step(16, 32, 0, 0);
    step(16, 24, 0, 0);
    step(16, 16, 0, 0);

    // Reversal: ramp to 0, dwell two periods, flip, then slew negative.
    step(-16, 8, 0, 0);
    step(-16, 0, 0, 0);
    step(-16, 0, 0, 1);
    step(-16, 0, 0, 1);
    step(-16, 0, 1, 0);
    step(-16, -8, 1, 0);
    step(-16, -16, 1, 0);

    // -512 is clamped: ramp ends at -511, a full period of pwm high.
    for (int k = 1; k <= 61; k++)
      step(-512, -16 - 8 * k, 1, 0);
    step(-512, -511, 1, 0);
    // Held at -511; enable drops on this period's first clock, so pwm is
    // high for count 0 only.
    step_h(-512, -511, 1, 0, 1);

    wait_tick();
    target_speed = 10'sd100;
    enable       = 1'b0;
    @(negedge clock);
    $display("enable drop at -511: pwm=%0d applied=%0d dir=%0d", pwm, applied_speed, dir);
    check("drop1_pwm", int'(pwm), 0);
    check("drop1_applied", int'(applied_speed), 0);
    check("drop1_dir", int'(dir), 1);
    check("drop1_brake", int'(brake), int'(BRAKE_ON));
    enable = 1'b1;
    // Re-entry from IDLE takes dir from the +100 target with no dwell.
    push(0, 0, 0, 0);

    for (int k = 1; k <= 12; k++)
      step(100, 8 * k, 0, 0);
    // Enable drops at pwm_cnt=50: high for counts 0..50.
    step_h(100, 100, 0, 0, 51);

    wait_tick();
    repeat (50) @(negedge clock);
    enable = 1'b0;
    @(negedge clock);
    $display("enable drop at +100: pwm=%0d applied=%0d dir=%0d", pwm, applied_speed, dir);
    check("drop2_pwm", int'(pwm), 0);
    check("drop2_applied", int'(applied_speed), 0);
    check("drop2_dir", int'(dir), 0);
    check("drop2_brake", int'(brake), int'(BRAKE_ON));
    repeat (49) @(negedge clock);
    enable       = 1'b1;
    target_speed = 10'sd511;
    push(0, 0, 0, 0);

    // Full scale forward: the final period must be pwm high throughout.
    for (int k = 1; k <= 63; k++)
      step(511, 8 * k, 0, 0);
    step(511, 511, 0, 0);

    wait_tick();
    wait_tick();
    @(negedge clock);
    check("scoreboard_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
